multi_cycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back states from the 6-bit opcode, and drives every datapath enable and mux select. It produces the 2-bit aluOp that the ALU control decoder consumes. It stalls on a single-bit memory ready handshake.

---
 rtl/multi_cycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/memory/write-back).
// Optional addi support is compiled in when the ADDI_EN macro is defined.
module multi_cycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               memToReg,
    output logic               irWrite,
    output logic [1:0]         pcSource,
    output logic [1:0]         aluOp,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               regWrite,
    output logic               regDst,
    output logic               instrDone,
    output logic               illegalOp,
    output logic [STATE_W-1:0] stateOut
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t stateReg;
    state_t stateNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext   = FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        irWrite     = 1'b0;
        pcSource    = 2'b00;
        aluOp       = 2'b00;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;

        case (stateReg)
            FETCH: begin
                memRead   = 1'b1;
                aluSrcB   = 2'b01;
                // PC+4 and IR load only commit once memory returns the word
                irWrite   = memReady;
                pcWrite   = memReady;
                stateNext = memReady ? DECODE : FETCH;
            end
            DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     stateNext = EXEC;
                    OP_LW, OP_SW: stateNext = MEM_ADDR;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_J:         stateNext = JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      stateNext = ADDI_EX;
`endif
                    default: begin
                        // PC already advanced in FETCH, so this retires as a NOP
                        illegalOp = 1'b1;
                        instrDone = 1'b1;
                        stateNext = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                stateNext = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                memRead   = 1'b1;
                iorD      = 1'b1;
                stateNext = memReady ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
            MEM_WR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
                stateNext = memReady ? FETCH : MEM_WR;
            end
            EXEC: begin
                aluSrcA   = 1'b1;
                aluOp     = 2'b10;
                stateNext = R_WB;
            end
            R_WB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                instrDone   = 1'b1;
                stateNext   = FETCH;
            end
            JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
`ifdef ADDI_EN
            ADDI_EX: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                stateNext = ADDI_WB;
            end
            ADDI_WB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
`endif
            default: stateNext = FETCH;
        endcase

        // Reset overrides everything: enables off, selects parked at FETCH values
        if (!rst_n) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            regWrite    = 1'b0;
            instrDone   = 1'b0;
            illegalOp   = 1'b0;
            iorD        = 1'b0;
            memToReg    = 1'b0;
            pcSource    = 2'b00;
            aluOp       = 2'b00;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b01;
            regDst      = 1'b0;
        end
    end

    assign stateOut = STATE_W'(stateReg);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes expected state/outputs per cycle,
// a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       memReady = 1'b1;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite;
    logic [1:0] pcSource, aluOp, aluSrcB;
    logic       aluSrcA, regWrite, regDst, instrDone, illegalOp;
    logic [3:0] stateOut;

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .irWrite(irWrite), .pcSource(pcSource), .aluOp(aluOp),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .regWrite(regWrite),
        .regDst(regDst), .instrDone(instrDone), .illegalOp(illegalOp),
        .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    // Output vector layout (MSB..LSB): pcWrite pcWriteCond iorD memRead memWrite memToReg
    // irWrite pcSource[1:0] aluOp[1:0] aluSrcA aluSrcB[1:0] regWrite regDst instrDone illegalOp
    localparam logic [17:0] PCW   = 18'h1 << 17;
    localparam logic [17:0] PCWC  = 18'h1 << 16;
    localparam logic [17:0] IORD  = 18'h1 << 15;
    localparam logic [17:0] MRD   = 18'h1 << 14;
    localparam logic [17:0] MWR   = 18'h1 << 13;
    localparam logic [17:0] M2R   = 18'h1 << 12;
    localparam logic [17:0] IRW   = 18'h1 << 11;
    localparam logic [17:0] PS_AO = 18'h1 << 9;
    localparam logic [17:0] PS_J  = 18'h2 << 9;
    localparam logic [17:0] OPSUB = 18'h1 << 7;
    localparam logic [17:0] OPFN  = 18'h2 << 7;
    localparam logic [17:0] SRCA  = 18'h1 << 6;
    localparam logic [17:0] SB4   = 18'h1 << 4;
    localparam logic [17:0] SBIMM = 18'h2 << 4;
    localparam logic [17:0] SBSH  = 18'h3 << 4;
    localparam logic [17:0] RW    = 18'h1 << 3;
    localparam logic [17:0] RDST  = 18'h1 << 2;
    localparam logic [17:0] DONE  = 18'h1 << 1;
    localparam logic [17:0] ILL   = 18'h1;

    localparam logic [17:0] E_RST   = SB4;
    localparam logic [17:0] E_FRDY  = MRD | SB4 | IRW | PCW;
    localparam logic [17:0] E_FSTL  = MRD | SB4;
    localparam logic [17:0] E_DEC   = SBSH;
    localparam logic [17:0] E_DECIL = SBSH | DONE | ILL;
    localparam logic [17:0] E_MADDR = SRCA | SBIMM;
    localparam logic [17:0] E_MRD   = MRD | IORD;
    localparam logic [17:0] E_MWB   = RW | M2R | DONE;
    localparam logic [17:0] E_MWRR  = MWR | IORD | DONE;
    localparam logic [17:0] E_MWRS  = MWR | IORD;
    localparam logic [17:0] E_EXEC  = SRCA | OPFN;
    localparam logic [17:0] E_RWB   = RW | RDST | DONE;
    localparam logic [17:0] E_BR    = SRCA | OPSUB | PCWC | PS_AO | DONE;
    localparam logic [17:0] E_JMP   = PCW | PS_J | DONE;
`ifdef ADDI_EN
    localparam logic [17:0] E_AEX   = SRCA | SBIMM;
    localparam logic [17:0] E_AWB   = RW | DONE;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] vec;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    logic [17:0] actVec;
    assign actVec = {pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
                     pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst, instrDone, illegalOp};

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks = checks + 2;
            $display("txn %0d state %0d outputs %05h (want state %0d outputs %05h)",
                     txn, stateOut, actVec, e.st, e.vec);
            if (stateOut !== e.st) begin
                errors++;
                $display("FAIL txn%0d state got %0d want %0d", txn, stateOut, e.st);
            end
            if (actVec !== e.vec) begin
                errors++;
                $display("FAIL txn%0d outputs got %05h want %05h", txn, actVec, e.vec);
            end
            txn++;
        end
    end

    task automatic cyc(input logic rst, input logic mr, input logic [5:0] op,
                       input logic [3:0] st, input logic [17:0] v);
        rst_n    = rst;
        memReady = mr;
        opcode   = op;
        expQ.push_back({st, v});
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset held three cycles with memReady high
        repeat (3) cyc(1'b0, 1'b1, OP_R, 4'd0, E_RST);
        // R-type
        cyc(1'b1, 1'b1, OP_R, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_R, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_R, 4'd6, E_EXEC);
        cyc(1'b1, 1'b1, OP_R, 4'd7, E_RWB);
        // R-type with memReady low outside FETCH (must be ignored)
        cyc(1'b1, 1'b1, OP_R, 4'd0, E_FRDY);
        cyc(1'b1, 1'b0, OP_R, 4'd1, E_DEC);
        cyc(1'b1, 1'b0, OP_R, 4'd6, E_EXEC);
        cyc(1'b1, 1'b0, OP_R, 4'd7, E_RWB);
        // lw with two stall cycles in MEM_RD; opcode changes there are ignored
        cyc(1'b1, 1'b1, OP_LW, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_LW, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_LW, 4'd2, E_MADDR);
        cyc(1'b1, 1'b0, OP_BAD, 4'd3, E_MRD);
        cyc(1'b1, 1'b0, OP_BAD, 4'd3, E_MRD);
        cyc(1'b1, 1'b1, OP_BAD, 4'd3, E_MRD);
        cyc(1'b1, 1'b1, OP_BAD, 4'd4, E_MWB);
        // sw, no stall
        cyc(1'b1, 1'b1, OP_SW, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_SW, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_SW, 4'd2, E_MADDR);
        cyc(1'b1, 1'b1, OP_SW, 4'd5, E_MWRR);
        // sw with one stall in MEM_WR, preceded by a FETCH stall
        cyc(1'b1, 1'b0, OP_SW, 4'd0, E_FSTL);
        cyc(1'b1, 1'b1, OP_SW, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_SW, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_SW, 4'd2, E_MADDR);
        cyc(1'b1, 1'b0, OP_SW, 4'd5, E_MWRS);
        cyc(1'b1, 1'b1, OP_SW, 4'd5, E_MWRR);
        // beq
        cyc(1'b1, 1'b1, OP_BEQ, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_BEQ, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_BEQ, 4'd8, E_BR);
        // illegal opcode
        cyc(1'b1, 1'b1, OP_BAD, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_BAD, 4'd1, E_DECIL);
        // jump
        cyc(1'b1, 1'b1, OP_J, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_J, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_J, 4'd9, E_JMP);
        // addi: feature-dependent
        cyc(1'b1, 1'b1, OP_ADDI, 4'd0, E_FRDY);
`ifdef ADDI_EN
        cyc(1'b1, 1'b1, OP_ADDI, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_ADDI, 4'd10, E_AEX);
        cyc(1'b1, 1'b1, OP_ADDI, 4'd11, E_AWB);
`else
        cyc(1'b1, 1'b1, OP_ADDI, 4'd1, E_DECIL);
`endif
        // reset dropped during a FETCH stall
        cyc(1'b1, 1'b0, OP_R, 4'd0, E_FSTL);
        cyc(1'b0, 1'b0, OP_R, 4'd0, E_RST);
        cyc(1'b0, 1'b0, OP_R, 4'd0, E_RST);
        cyc(1'b1, 1'b0, OP_R, 4'd0, E_FSTL);
        cyc(1'b1, 1'b1, OP_R, 4'd0, E_FRDY);
        // reset dropped mid-cycle while in EXEC: state must return to FETCH at once
        cyc(1'b1, 1'b1, OP_R, 4'd1, E_DEC);
        cyc(1'b0, 1'b1, OP_R, 4'd0, E_RST);
        cyc(1'b1, 1'b1, OP_J, 4'd0, E_FRDY);
        cyc(1'b1, 1'b1, OP_J, 4'd1, E_DEC);
        cyc(1'b1, 1'b1, OP_J, 4'd9, E_JMP);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
